// File: rtl/div_disp_pkg.sv
`default_nettype none
// ============================================================================
// div_disp_pkg : shared types, segment codes and BCD helpers for the display
// Rev 1.0
// ============================================================================
package div_disp_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int ITER = 6;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    function automatic logic [3:0] dd_adj(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // One double-dabble step: adjust both nibbles, then shift in the next binary bit
    function automatic logic [7:0] dd_step(input logic [7:0] acc, input logic b);
        return ({dd_adj(acc[7:4]), dd_adj(acc[3:0])} << 1) | {7'd0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_result_display_seg7_decode.sv
`default_nettype none
// ============================================================================
// seg7_decode : 4-bit BCD digit to active-low 7-segment pattern with blanking
// Rev 1.0
// ============================================================================
module seg7_decode
    import div_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_result_display.sv
`default_nettype none
// ============================================================================
// div_result_display : converts divider q/r to BCD and scans a 4-digit display
// Rev 1.0
// ============================================================================
module div_result_display
    import div_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [5:0]  q,
    input  logic [5:0]  r,
    output logic        busy,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int              c_CW        = $clog2(REFRESH_DIV);
    localparam logic [c_CW-1:0] c_REF_LAST  = c_CW'(REFRESH_DIV - 1);
    localparam logic [c_CW-1:0] c_REF_ONE   = c_CW'(1);
    localparam logic [2:0]      c_LAST_ITER = 3'(ITER - 1);

    state_t          r_state;
    logic [5:0]      r_qbin;
    logic [5:0]      r_rbin;
    logic [7:0]      r_qacc;
    logic [7:0]      r_racc;
    logic [2:0]      r_cnt;
    logic            r_busy;
    logic [15:0]     r_bcd;
    logic            r_valid;
    logic [c_CW-1:0] r_refresh;
    logic [1:0]      r_sel;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;

    logic [7:0]      w_qacc_nxt;
    logic [7:0]      w_racc_nxt;
    logic [3:0]      w_digit;
    logic            w_blank;
    logic [3:0]      w_an_nxt;
    logic [6:0]      w_seg_nxt;

    assign w_qacc_nxt = dd_step(r_qacc, r_qbin[5]);
    assign w_racc_nxt = dd_step(r_racc, r_rbin[5]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_qbin  <= 6'd0;
            r_rbin  <= 6'd0;
            r_qacc  <= 8'd0;
            r_racc  <= 8'd0;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b0;
            r_bcd   <= 16'h0000;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_qbin  <= q;
                        r_rbin  <= r;
                        r_qacc  <= 8'd0;
                        r_racc  <= 8'd0;
                        r_cnt   <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_qacc <= w_qacc_nxt;
                    r_racc <= w_racc_nxt;
                    r_qbin <= {r_qbin[4:0], 1'b0};
                    r_rbin <= {r_rbin[4:0], 1'b0};
                    r_cnt  <= r_cnt + 3'd1;
                    // Publish only the finished result so the display never sees partial digits
                    if (r_cnt == c_LAST_ITER) begin
                        r_bcd   <= {w_qacc_nxt, w_racc_nxt};
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_digit  = r_bcd[3:0];
        w_blank  = 1'b0;
        w_an_nxt = 4'b1110;
        case (r_sel)
            2'd0: begin
                w_digit  = r_bcd[3:0];
                w_an_nxt = 4'b1110;
            end
            2'd1: begin
                w_digit  = r_bcd[7:4];
                w_blank  = (r_bcd[7:4] == 4'd0);
                w_an_nxt = 4'b1101;
            end
            2'd2: begin
                w_digit  = r_bcd[11:8];
                w_an_nxt = 4'b1011;
            end
            default: begin
                w_digit  = r_bcd[15:12];
                w_blank  = (r_bcd[15:12] == 4'd0);
                w_an_nxt = 4'b0111;
            end
        endcase
    end

    seg7_decode u_seg7 (
        .i_bcd   (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg_nxt)
    );

    // Refresh scan is free-running and independent of the conversion FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_sel     <= 2'd0;
            r_an      <= 4'b1111;
            r_seg     <= SEG_BLANK;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            if (r_refresh == c_REF_LAST) begin
                r_refresh <= '0;
                r_sel     <= r_sel + 2'd1;
            end else begin
                r_refresh <= r_refresh + c_REF_ONE;
            end
        end
    end

    assign busy      = r_busy;
    assign bcd       = r_bcd;
    assign bcd_valid = r_valid;
    assign an        = r_an;
    assign seg       = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_div_result_display.sv
`default_nettype none
// ============================================================================
// tb_div_result_display : randomized scoreboard bench for div_result_display
// Rev 1.0
// ============================================================================
module tb_div_result_display;

    localparam int c_RD   = 4;
    localparam int c_ITER = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [5:0]  q;
    logic [5:0]  r;
    logic        busy;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic [3:0]  an;
    logic [6:0]  seg;

    div_result_display #(.REFRESH_DIV(c_RD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb_q[$];
    bit          mon_en = 1'b0;
    logic        prev_busy = 1'b0;

    int          m_left  = 0;
    int          m_cycle = 0;
    int          m_sel   = 0;
    logic [15:0] m_pend  = 16'h0;
    logic [15:0] m_bcd   = 16'h0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_an    = 4'hF;
    logic [6:0]  m_seg   = 7'h7F;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int qv, input int rv);
        return {4'(qv / 10), 4'(qv % 10), 4'(rv / 10), 4'(rv % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d, input bit is_tens);
        logic [6:0] codes [0:15];
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        if (is_tens && d == 4'd0) return 7'h7F;
        return codes[d];
    endfunction

    // Reference model: a conversion takes 6 edges, the display scans digits every c_RD edges
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  = 0;
            m_cycle = 0;
            m_bcd   = 16'h0;
            m_valid = 1'b0;
            m_an    = 4'hF;
            m_seg   = 7'h7F;
            sb_q.delete();
        end else begin
            m_sel = (m_cycle / c_RD) % 4;
            case (m_sel)
                0:       begin m_an = 4'b1110; m_seg = seg_of(m_bcd[3:0],   1'b0); end
                1:       begin m_an = 4'b1101; m_seg = seg_of(m_bcd[7:4],   1'b1); end
                2:       begin m_an = 4'b1011; m_seg = seg_of(m_bcd[11:8],  1'b0); end
                default: begin m_an = 4'b0111; m_seg = seg_of(m_bcd[15:12], 1'b1); end
            endcase
            m_cycle++;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd   = m_pend;
                    m_valid = 1'b1;
                end
            end else if (load) begin
                m_left = c_ITER;
                m_pend = to_bcd(int'(q), int'(r));
                sb_q.push_back(m_pend);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(m_left > 0));
            chk("an", 32'(an), 32'(m_an));
            chk("seg", 32'(seg), 32'(m_seg));
            chk("bcd_hold", 32'(bcd), 32'(m_bcd));
            chk("bcd_valid", 32'(bcd_valid), 32'(m_valid));
            if (rst_n) begin
                if (prev_busy && !busy) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_result", 32'(bcd), 32'hFFFF_FFFF);
                    end else begin
                        chk("sb_bcd", 32'(bcd), 32'(sb_q.pop_front()));
                    end
                end
                prev_busy = busy;
            end else begin
                prev_busy = 1'b0;
            end
        end
    end

    task automatic do_load(input int qv, input int rv);
        load = 1'b1;
        q    = 6'(qv);
        r    = 6'(rv);
        @(negedge clk);
        load = 1'b0;
        q    = 6'($urandom_range(0, 63));
        r    = 6'($urandom_range(0, 63));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  32'(busy),      32'h0);
        chk({tag, "_bcd"},   32'(bcd),       32'h0);
        chk({tag, "_valid"}, 32'(bcd_valid), 32'h0);
        chk({tag, "_an"},    32'(an),        32'hF);
        chk({tag, "_seg"},   32'(seg),       32'h7F);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        q     = 6'd0;
        r     = 6'd0;
        idle(3);
        chk_reset("por");
        mon_en = 1'b1;
        rst_n  = 1'b1;

        do_load(21, 5);   idle(10);
        do_load(63, 63);  idle(8);
        do_load(0, 0);    idle(8);

        // Second load at N+2 and a load in the final CONV cycle are both dropped
        do_load(10, 3);   idle(1);
        do_load(1, 1);    idle(3);
        do_load(7, 7);
        do_load(1, 1);    idle(8);

        do_load(9, 7);    idle(20);
        do_load(33, 44);  idle(30);

        // Asynchronous reset in the third conversion cycle
        do_load(50, 50);  idle(2);
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        idle(2);
        #2 rst_n = 1'b1;
        @(negedge clk);
        do_load(42, 17);  idle(10);

        repeat (40) begin
            do_load(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            idle(int'($urandom_range(0, 9)));
        end
        idle(10);
        chk("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_result_display.md
Name: div_result_display

Overview:
- Downstream consumer of the 6-bit divider's quotient and remainder.
- On a load strobe it captures q and r and converts each to two BCD digits with an iterative shift-add-3 (double-dabble), one shift per clock.
- Drives a 4-digit, time-multiplexed, active-low 7-segment display: quotient on the left two digits, remainder on the right two.

Parameters:
- REFRESH_DIV, 4096: clock cycles each digit stays enabled; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  single-cycle strobe; capture q and r and start conversion
- q  input  6  quotient from the divider (0..63)
- r  input  6  remainder from the divider (0..63)
- busy  output  1  conversion in progress
- bcd  output  16  {q_tens, q_ones, r_tens, r_ones}, registered
- bcd_valid  output  1  high once any conversion has completed; sticky until reset
- an  output  4  digit enables, active-low one-hot; an[0]=r_ones, an[1]=r_tens, an[2]=q_ones, an[3]=q_tens
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous active-low and takes effect immediately, including mid-conversion.
- Reset values:
  - busy=0, bcd=16'h0000, bcd_valid=0.
  - an=4'b1111, seg=7'h7F.
  - FSM in IDLE; refresh counter=0; digit select=0.
- FSM states: IDLE and CONV.
- IDLE:
  - load=1 at edge N captures q and r into two 6-bit shift registers.
  - Clears the two 8-bit BCD accumulators and the iteration count.
  - busy=1 from edge N; next state CONV.
  - load=0: stay in IDLE.
- CONV, each edge:
  - Per accumulator, add 3 to every nibble >= 5.
  - Then shift {acc, bin} left by 1.
  - Increment the count.
- Sixth shift (edge N+6):
  - bcd <= both accumulators after the sixth shift, in the same edge.
  - bcd_valid <= 1, busy <= 0, next state IDLE.
  - bcd changes only at this edge; the display never shows a partial result.
- Latency: busy is high for exactly 6 cycles. The new bcd is visible after edge N+6. The earliest next accepted load is sampled at edge N+7.
- load while busy=1, including the final CONV cycle, is ignored. No queuing.
- Range: tens digit 0..6, ones digit 0..9; 6 bits never overflow two BCD digits.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit select increments modulo 4 (3 -> 0).
  - Runs continuously and is independent of the FSM.
- Display outputs:
  - an and seg are registered from the current digit select and bcd.
  - First edge after reset release: an=4'b1110, showing r_ones.
- Leading-zero blanking:
  - q_tens=0 or r_tens=0: that digit's seg=7'h7F, but its an is still asserted.
  - Ones digits are always shown, including 0.
- Seg codes {g..a}, active-low, for digits 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).

Decomposition:
- Package div_disp_pkg holds:
  - the state enum (IDLE, CONV);
  - SEG_BLANK=7'h7F;
  - the ten SEG_n digit constants;
  - the ITER=6 constant.
- One natural sub-module: seg7_decode. It is combinational: 4-bit BCD plus blank -> 7-bit active-low segments.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-stream -> immediately busy=0, bcd=0, bcd_valid=0, an=4'b1111, seg=7'h7F.
- Basic conversion:
  - Stimulus: q=21, r=5, load at edge N.
  - busy=1 for 6 cycles.
  - After edge N+6: bcd=16'h2105, bcd_valid=1, busy=0.
- Maximum values: q=63, r=63 -> bcd=16'h6363. q=0, r=0 -> bcd=16'h0000.
- Load while busy:
  - Stimulus: load q=10, r=3; then load q=1, r=1 two cycles later.
  - Second load ignored; bcd=16'h1003.
  - Next load sampled at edge N+7 converts q=1, r=1 to 16'h0101.
- Display scan:
  - Setup: REFRESH_DIV=4, bcd=16'h0907.
  - an cycles 1110, 1101, 1011, 0111, each held 4 cycles, then repeats.
  - seg values in that order: 78 (7), 7F (blank), 10 (9), 7F (blank).
  - bcd must not change during the scan, including while a conversion is busy.
- Reset mid-conversion:
  - Drop rst_n in the 3rd CONV cycle -> busy=0, bcd=0, bcd_valid=0.
  - After release, load q=42, r=17 -> bcd=16'h4217 after 6 cycles.
